ifu_step_controller: RTL
========================

# ifu_step_controller

Sequencing controller for the instruction fetch unit: it generates the single-cycle PC-advance strobe that steps the IFU, replacing a free-running divided clock. The IFU, ClkDiv and display all run on the board `Clk`. Supported modes are free-run at a programmable rate, debounced single-step from a push button, and halt on a PC breakpoint. A 16-bit fetch counter is provided for the display.

## Interface
Parameters:
- `DIV_WIDTH`, 26: width of run-rate prescaler and `Rate` input.
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable cycles required to accept a button level change; must be ≥ 2.

Ports:
- `Clk`  in  1  system clock; all state on its rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `RunSw`  in  `1`  raw run switch; level; asynchronous to `Clk`.
- `StepBtn`  in  1  raw step push button; asynchronous; bouncy.
- `BrkEn`  in  1  breakpoint enable; synchronous, quasi-static.
- `BrkAddr`  in  32  breakpoint PC value.
- `Rate`  in  `DIV_WIDTH`  run period minus one, in cycles.
- `PC`  in  32  current IFU PC.
- `PcEn`  out  1  registered one-cycle PC-advance strobe to IFU.
- `State`  out  2  FSM state: 0 IDLE, 1 RUN, 2 STEP, 3 HALT.
- `Halted`  out  1  high while `State` is HALT.
- `FetchCount`  out  16  number of `PcEn` pulses issued; wraps.

## Operation
Input conditioning:
- `RunSw` and `StepBtn` each pass through a 2-FF synchronizer. The synchronized signals are `run_s` and `btn_s`.
- The debouncer holds level `deb`. A counter counts consecutive cycles with `btn_s != deb` and clears when they are equal. When the counter reaches `DEBOUNCE_CYCLES-1` while they still differ, `deb <= btn_s` and the counter clears.
- `step_req = deb & ~deb_q`: a one-cycle pulse on each accepted press. Releases generate nothing.

FSM (registered):
- IDLE:
  - If `run_s`, go to RUN and clear the prescaler.
  - Otherwise, if `step_req`, go to STEP.
  - `run_s` has priority over `step_req`.
- STEP: `PcEn` is high for exactly this one cycle. The next state is always IDLE. The breakpoint is ignored, so stepping off `BrkAddr` is allowed.
- RUN, evaluated in priority order:
  - If `!run_s`, go to IDLE with no pulse, even if a tick is due.
  - Otherwise, if the prescaler equals `Rate`, clear the prescaler, then:
    - if `BrkEn && PC == BrkAddr`, go to HALT with no pulse;
    - else assert `PcEn` for the next cycle.
  - Otherwise, increment the prescaler.
  - `step_req` is ignored in RUN.
- HALT:
  - If `!run_s`, go to IDLE.
  - Otherwise, if `step_req`, go to STEP. On returning to IDLE, `run_s` is still high, so the FSM re-enters RUN.
- `FetchCount` increments on every cycle `PcEn` is high and wraps from 0xFFFF to 0x0000.
- `Rate == 0` gives a `PcEn` pulse every cycle in RUN. Run period is `Rate+1` cycles.
- `Rate` changes take effect at the next compare. If `Rate` drops below the current prescaler value, the prescaler counts up to the `DIV_WIDTH` wrap before matching; this is accepted.

## Timing
- Reset, asynchronous and immediate, sets:
  - `State`=IDLE, `PcEn`=0, `Halted`=0, `FetchCount`=0;
  - prescaler, debounce counter, `deb`, `deb_q` and both synchronizers to 0.
- A button held through reset release yields exactly one step after debounce.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `PcEn` rises at the same edge at which `State` becomes STEP, or at the RUN tick edge. It is never high for two consecutive cycles, except in RUN with `Rate==0`.
- Step latency: let e0 be the first edge at which sync stage 1 samples `StepBtn`=1.
  - `deb` rises at edge e0+`DEBOUNCE_CYCLES`.
  - `PcEn` rises at e0+`DEBOUNCE_CYCLES`+1 and falls one edge later.
- Run latency: `run_s` goes high 2 edges after `RunSw` is sampled. RUN is entered 1 edge later. The first `PcEn` follows after `Rate+1` further edges.
- Breakpoint: compared against the `PC` value present at the tick edge. The instruction at `BrkAddr` remains fetched. `Halted` rises at that edge.
- Simultaneous tick and `!run_s`: the state goes to IDLE and no pulse is issued.
- Reset mid-pulse: `PcEn` drops immediately, and the count is not incremented.

## Test plan
- Reset, with `DEBOUNCE_CYCLES`=4: all outputs zero. Press `StepBtn` cleanly for 10 cycles, then release. Required: exactly one `PcEn` pulse at e0+5, and `FetchCount`=1.
- Bounce: `StepBtn` toggles every 2 cycles for 12 cycles, then holds high. Required: no pulse during bouncing, then one pulse after 4 stable cycles.
- `RunSw`=1, `Rate`=3, for 40 cycles. Required: `PcEn` pulses every 4 cycles, 1 cycle wide. `FetchCount` matches the pulse count (9 or 10 depending on entry phase; checked exactly against the model).
- `Rate`=0, run for 8 cycles after entry. Required: `PcEn` is continuously high and `FetchCount`=8.
- `BrkEn`=1, `BrkAddr`=0x0000000C, with the IFU model advancing `PC` by 4 per `PcEn`, `Rate`=1. Required: `PcEn` pulses at PC 0, 4 and 8. `Halted` goes to 1 at PC=0xC with no further `PcEn`. A step press gives one `PcEn` (PC becomes 0x10), and the FSM then resumes RUN.
- Deassert `RunSw` on the exact tick cycle, and assert `Reset` mid-run with `FetchCount`=0xFFFF preloaded by 65535 pulses. Required: no pulse on the stop; wrap to 0x0000 on the next pulse; reset clears all outputs asynchronously.

Source files
------------

// File: rtl/ifu_step_controller.sv
// rtl/ifu_step_controller.sv - IFU PC-advance strobe sequencer: free-run, debounced single-step, PC breakpoint halt
module ifu_step_controller #(
  parameter int DIV_WIDTH       = 26,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 RunSw,
  input  logic                 StepBtn,
  input  logic                 BrkEn,
  input  logic [31:0]          BrkAddr,
  input  logic [DIV_WIDTH-1:0] Rate,
  input  logic [31:0]          PC,
  output logic                 PcEn,
  output logic [1:0]           State,
  output logic                 Halted,
  output logic [15:0]          FetchCount
);

  // Counter only has to reach DEBOUNCE_CYCLES-2; the flip happens on the edge
  // where it would become DEBOUNCE_CYCLES-1, so deb follows e0 by DEBOUNCE_CYCLES.
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_HALT = 2'd3
  } state_t;

  logic                 run_meta_q, run_s_q;
  logic                 btn_meta_q, btn_s_q;
  logic [DEB_W-1:0]     deb_cnt_q, deb_cnt_d;
  logic                 deb_q, deb_d;
  logic                 deb_dly_q;
  logic                 step_req;
  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] presc_q, presc_d;
  logic                 pcen_q, pcen_d;
  logic                 halted_q;
  logic [15:0]          fetch_cnt_q;

  // Two-flop synchronizers for the asynchronous switch and button
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      run_meta_q <= 1'b0;
      run_s_q    <= 1'b0;
      btn_meta_q <= 1'b0;
      btn_s_q    <= 1'b0;
    end else begin
      run_meta_q <= RunSw;
      run_s_q    <= run_meta_q;
      btn_meta_q <= StepBtn;
      btn_s_q    <= btn_meta_q;
    end
  end

  // Debounce: accept a new button level after it has differed long enough
  always_comb begin
    deb_cnt_d = '0;
    deb_d     = deb_q;
    if (btn_s_q != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d     = btn_s_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  // Debounce state and the delayed copy used for press edge detection
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      deb_cnt_q <= '0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
    end
  end

  assign step_req = deb_q & ~deb_dly_q;

  // Next-state, prescaler and strobe decisions; run switch dominates step
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    pcen_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run_s_q) begin
          state_d = S_RUN;
          presc_d = '0;
        end else if (step_req) begin
          state_d = S_STEP;
          pcen_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (!run_s_q) begin
          state_d = S_IDLE;
        end else if (presc_q == Rate) begin
          presc_d = '0;
          if (BrkEn && (PC == BrkAddr)) begin
            state_d = S_HALT;
          end else begin
            pcen_d = 1'b1;
          end
        end else begin
          presc_d = presc_q + DIV_WIDTH'(1);
        end
      end
      S_STEP: begin
        state_d = S_IDLE;
      end
      S_HALT: begin
        if (!run_s_q) begin
          state_d = S_IDLE;
        end else if (step_req) begin
          state_d = S_STEP;
          pcen_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state, registered outputs and the wrapping fetch counter
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      pcen_q      <= 1'b0;
      halted_q    <= 1'b0;
      fetch_cnt_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      pcen_q   <= pcen_d;
      halted_q <= (state_d == S_HALT);
      if (pcen_q) begin
        fetch_cnt_q <= fetch_cnt_q + 16'd1;
      end
    end
  end

  assign PcEn       = pcen_q;
  assign State      = state_q;
  assign Halted     = halted_q;
  assign FetchCount = fetch_cnt_q;

endmodule
